red_pitaya_pfd_unwrap: RTL
==========================

Name: red_pitaya_pfd_unwrap

Overview:
Downstream stage of the PFD quadrant detector. It consumes the 2-bit quadrant code each cycle and accumulates signed quadrant steps, giving an unwrapped phase-difference signal. The result is truncated to 14 bits for the DAC/PID path. It also flags ambiguous 180° jumps (slips) and overflow.

Parameters:
ISR, 0, extra LSB fractional bits; accumulator width W = 14+ISR, phase_o = acc[W-1:ISR]
SLIPW, 16, width of the saturating slip counter

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset, asynchronous, active-low
quad_i  in  2  quadrant code from the PFD block: 00=0°, 01=90°, 10=180°, 11=270°
clear_i  in  1  synchronous clear of accumulator, flags and counter
wrap_i  in  1  overflow mode: 0 = saturate/hold, 1 = two's-complement wrap
phase_o  out  14  signed unwrapped phase, 1 LSB = 2^ISR quadrant steps
valid_o  out  1  high once a reference sample has been captured
slip_o  out  1  one-cycle pulse on an ambiguous (delta=2) transition
slip_cnt_o  out  SLIPW  saturating count of slips
sat_o  out  1  sticky flag: an overflow occurred (either mode)

Behaviour:
- Reset (rstn_i low, asynchronous): acc=0, prev=00, state=IDLE; all outputs 0 immediately, without waiting for a clock edge. Deassertion takes effect at the next clk_i edge.
- States:
  - IDLE: the next edge captures prev<=quad_i, sets valid_o=1, goes to TRACK, and does not change acc.
  - TRACK: every edge computes delta = (quad_i - prev) mod 4, then sets prev<=quad_i.
- Delta decode:
  - 0: hold.
  - 1: acc+1.
  - 3: acc-1.
  - 2: acc unchanged, slip_o=1 for that cycle, slip_cnt+1 (saturates at all-ones).
- Latency: quad_i sampled at edge n appears in phase_o, slip_o and sat_o after edge n. All outputs are registers, or direct slices of registers.
- Overflow, wrap_i=0:
  - +1 at acc=2^(W-1)-1 holds the value and sets sat_o.
  - -1 at acc=-2^(W-1) holds the value and sets sat_o.
- Overflow, wrap_i=1: acc wraps in two's complement and sat_o is set.
- sat_o and slip_cnt_o are sticky; only clear_i or reset clears them.
- clear_i: highest synchronous priority. At that edge acc=0, sat_o=0, slip_cnt=0, slip_o=0, valid_o=0, state=IDLE. Any step at that edge is discarded. The following edge re-captures prev.
- wrap_i may change at any time; it applies to the current edge's update.
- quad_i is a registered PFD output in the same clock domain, so no synchronizer is needed.

Decomposition:
- Shared package (red_pitaya_pfd_pkg):
  - quadrant code constants (Q0/Q90/Q180/Q270)
  - delta enum (HOLD, UP, DOWN, SLIP)
  - state enum (IDLE, TRACK)
  - PHASE_W=14
- One natural sub-module, red_pitaya_sat_updown. It is a W-bit signed up/down accumulator with hold/wrap mode, sync clear, async reset and an overflow strobe, and is reusable by other PFD/counter paths.
- Delta decode and slip counter stay inline.

Test Plan:
1. ISR=0, reset release, quad_i 00,01,10,11,00 on consecutive edges -> first edge valid_o=1 with phase_o=0, then phase_o 1,2,3,4 (0x0004); slip_o never high.
2. From 0, sequence 00,11,10,01,00 -> phase_o -1..-4, ending at 0x3FFC; sat_o=0.
3. In TRACK with prev=00, apply quad_i=10 -> slip_o high exactly one cycle, phase_o unchanged, slip_cnt_o=1. Repeat 70000 slips with SLIPW=16 -> slip_cnt_o holds 0xFFFF.
4. ISR=0, wrap_i=0: 8191 forward steps give phase_o=0x1FFF; one more step -> phase_o stays 0x1FFF, sat_o=1. Repeat with wrap_i=1 -> phase_o=0x2000 (-8192), sat_o=1.
5. ISR=2, 4 forward steps -> phase_o=1; 3 steps -> phase_o=0.
6. Two cases:
   - clear_i asserted in the same cycle as an UP step -> after that edge phase_o=0, valid_o=0, sat_o=0; next edge only re-captures.
   - rstn_i pulled low between edges mid-count -> all outputs 0 before the next clk_i edge.

Source files
------------

// File: rtl/red_pitaya_pfd_pkg.sv
// Shared types and constants for the PFD quadrant-unwrap path.
package red_pitaya_pfd_pkg;

  localparam int PHASE_W = 14;

  localparam logic [1:0] Q0   = 2'b00;
  localparam logic [1:0] Q90  = 2'b01;
  localparam logic [1:0] Q180 = 2'b10;
  localparam logic [1:0] Q270 = 2'b11;

  // A delta is a quadrant distance, so it reuses the quadrant codes.
  typedef enum logic [1:0] {
    HOLD = Q0,
    UP   = Q90,
    SLIP = Q180,
    DOWN = Q270
  } delta_e;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_e;

endpackage

// File: rtl/red_pitaya_sat_updown.sv
// W-bit signed up/down accumulator with hold-or-wrap overflow, sync clear
// and a combinational overflow strobe for the step applied this cycle.
module red_pitaya_sat_updown #(
  parameter int W = 14
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clear_i,
  input  logic         up_i,
  input  logic         dn_i,
  input  logic         wrap_i,
  output logic [W-1:0] acc_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] acc_q, acc_d;
  logic         hit;

  always_comb begin
    hit   = 1'b0;
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (up_i) begin
      hit   = (acc_q == MAX);
      acc_d = (hit && !wrap_i) ? acc_q : acc_q + W'(1);
    end else if (dn_i) begin
      hit   = (acc_q == MIN);
      acc_d = (hit && !wrap_i) ? acc_q : acc_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign acc_o = acc_q;
  assign ovf_o = hit;

endmodule

// File: rtl/red_pitaya_pfd_unwrap.sv
// Unwraps the PFD quadrant code into a signed phase accumulator, counting
// ambiguous half-turn jumps and flagging accumulator overflow.
module red_pitaya_pfd_unwrap
  import red_pitaya_pfd_pkg::*;
#(
  parameter int ISR   = 0,
  parameter int SLIPW = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [1:0]         quad_i,
  input  logic               clear_i,
  input  logic               wrap_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic               valid_o,
  output logic               slip_o,
  output logic [SLIPW-1:0]   slip_cnt_o,
  output logic               sat_o
);

  localparam int W = PHASE_W + ISR;

  state_e           state_q, state_d;
  logic [1:0]       prev_q;
  logic             valid_q, valid_d;
  logic             slip_q, slip_d;
  logic [SLIPW-1:0] slip_cnt_q;
  logic             sat_q;
  logic [1:0]       diff;
  delta_e           delta;
  logic             up, dn, ovf;
  logic [W-1:0]     acc;

  assign diff  = quad_i - prev_q;
  assign delta = delta_e'(diff);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    slip_d  = 1'b0;
    up      = 1'b0;
    dn      = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = TRACK;
        valid_d = 1'b1;
      end
      TRACK: begin
        case (delta)
          UP:      up     = 1'b1;
          DOWN:    dn     = 1'b1;
          SLIP:    slip_d = 1'b1;
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
    // Clear wins over everything, including a step arriving on the same edge.
    if (clear_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      slip_d  = 1'b0;
      up      = 1'b0;
      dn      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      prev_q     <= Q0;
      valid_q    <= 1'b0;
      slip_q     <= 1'b0;
      slip_cnt_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= quad_i;
      valid_q <= valid_d;
      slip_q  <= slip_d;
      if (clear_i) begin
        slip_cnt_q <= '0;
        sat_q      <= 1'b0;
      end else begin
        if (slip_d && !(&slip_cnt_q)) slip_cnt_q <= slip_cnt_q + SLIPW'(1);
        if (ovf) sat_q <= 1'b1;
      end
    end
  end

  red_pitaya_sat_updown #(.W(W)) u_acc (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear_i (clear_i),
    .up_i    (up),
    .dn_i    (dn),
    .wrap_i  (wrap_i),
    .acc_o   (acc),
    .ovf_o   (ovf)
  );

  assign phase_o    = acc[W-1:ISR];
  assign valid_o    = valid_q;
  assign slip_o     = slip_q;
  assign slip_cnt_o = slip_cnt_q;
  assign sat_o      = sat_q;

endmodule
